// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle: instruction-memory address/data plus the decode valid/ready handshake.
// The master modport is the fetch sequencer; the slave modport is the memory/decode side.
interface fetch_sequencer_if;
  logic [31:0] pc_o;
  logic [31:0] instr_i;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  modport master (
    output pc_o,
    input  instr_i,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc
  );

  modport slave (
    input  pc_o,
    output instr_i,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, fetches from a zero-latency instruction memory into a 2-entry buffer.
// Optional macro FETCH_PERF_EN adds the fetch_cnt / stall_cnt performance counters.
module fetch_sequencer #(
  parameter int unsigned MEM_WORDS = 256,
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  fetch_sequencer_if.master fif,
  output logic              busy,
  output logic              halted,
  output logic              fault
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, HALT, FAULT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        v0_q, v1_q;
  logic [31:0] i0_q, p0_q, i1_q, p1_q;

  logic go_start, go_redir, flush, deq, slot, in_range, is_halt, enq;

  assign fif.pc_o      = pc_q;
  assign fif.out_valid = v0_q;
  assign fif.out_instr = i0_q;
  assign fif.out_pc    = p0_q;

  // Next-state / next-PC decode; start beats redirect, redirect beats fetch.
  always_comb begin
    go_start = start && (state_q != RUN);
    go_redir = !go_start && redirect && (state_q != FAULT);
    flush    = go_start || go_redir;
    deq      = v0_q && fif.out_ready;
    slot     = !v1_q || deq;
    in_range = pc_q < 32'(MEM_WORDS);
    is_halt  = fif.instr_i == HALT_WORD;
    enq      = (state_q == RUN) && !flush && slot && in_range && !is_halt;
    state_d  = state_q;
    pc_d     = pc_q;
    if (go_start) begin
      state_d = RUN;
      pc_d    = RESET_PC;
    end else if (go_redir) begin
      state_d = RUN;
      pc_d    = redirect_pc;
    end else if (state_q == RUN) begin
      if (!in_range)
        state_d = FAULT;
      else if (slot && is_halt)
        state_d = HALT;
      else if (enq)
        pc_d = pc_q + 32'd1;
    end
  end

  // State, status flags and the head/tail buffer entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      busy    <= 1'b0;
      halted  <= 1'b0;
      fault   <= 1'b0;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      i0_q    <= 32'd0;
      p0_q    <= 32'd0;
      i1_q    <= 32'd0;
      p1_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      busy    <= state_d == RUN;
      halted  <= state_d == HALT;
      fault   <= state_d == FAULT;
      if (flush) begin
        v0_q <= 1'b0;
        v1_q <= 1'b0;
      end else begin
        case ({deq, enq})
          2'b10: begin
            v0_q <= v1_q;
            i0_q <= i1_q;
            p0_q <= p1_q;
            v1_q <= 1'b0;
          end
          2'b01: begin
            if (!v0_q) begin
              v0_q <= 1'b1;
              i0_q <= fif.instr_i;
              p0_q <= pc_q;
            end else begin
              v1_q <= 1'b1;
              i1_q <= fif.instr_i;
              p1_q <= pc_q;
            end
          end
          2'b11: begin
            // Pop and push together: the tail moves up if present, else the new word becomes head.
            if (v1_q) begin
              i0_q <= i1_q;
              p0_q <= p1_q;
              i1_q <= fif.instr_i;
              p1_q <= pc_q;
            end else begin
              i0_q <= fif.instr_i;
              p0_q <= pc_q;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic stall;

  assign stall = (state_q == RUN) && v1_q && !deq;

  // Saturating counters; cleared by reset and start only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt <= 32'd0;
      stall_cnt <= 32'd0;
    end else if (go_start) begin
      fetch_cnt <= 32'd0;
      stall_cnt <= 32'd0;
    end else begin
      if (enq && (fetch_cnt != 32'hFFFF_FFFF))
        fetch_cnt <= fetch_cnt + 32'd1;
      if (stall && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller in front of the combinational 256-word instruction memory. Owns the program counter and drives it to the memory's `PC` input each cycle. Captures the returned `dataout` word into a 2-entry prefetch buffer and presents instructions to decode over a valid/ready handshake. Handles start, branch redirect with flush, halt-word detection and out-of-range PC faults.

## Interface
- `MEM_WORDS`, default 256: instruction memory depth in words; valid PCs are 0..MEM_WORDS-1.
- `RESET_PC`, default 32'd0: PC loaded at reset and on `start`.
- `HALT_WORD`, default 32'hFFFF_FFFF: fetched word that stops fetching.
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse; from IDLE, HALT or FAULT, begins fetching at RESET_PC.
- `redirect` in 1: branch/jump taken; flush the buffer and refetch.
- `redirect_pc` in 32: word-address target of the redirect.
- `pc_o` out 32: word address to the instruction memory `PC` port; equals the internal `pc_q`.
- `instr_i` in 32: instruction memory `dataout`, valid in the same cycle as `pc_o`.
- `out_valid` out 1: buffer head is valid.
- `out_ready` in 1: decode accepts the head this cycle.
- `out_instr` out 32: buffer head instruction.
- `out_pc` out 32: PC of the buffer head.
- `busy` out 1: state is RUN.
- `halted` out 1: state is HALT.
- `fault` out 1: state is FAULT.

## Operation
- States: IDLE (after reset), RUN, HALT, FAULT.
- IDLE/HALT/FAULT -> RUN on `start`: `pc_q`<=RESET_PC, buffer flushed.
- IDLE/HALT -> RUN on `redirect`: `pc_q`<=`redirect_pc`, buffer flushed.
- `redirect` is ignored in FAULT; only `start` or `rst` leaves FAULT.
- In RUN, a fetch slot exists when count<2, or count==2 and a dequeue occurs this cycle.
- Fetch slot with `pc_q`<MEM_WORDS and `instr_i`!=HALT_WORD: enqueue {`instr_i`, `pc_q`}, `pc_q`<=`pc_q`+1.
- Fetch slot with `instr_i`==HALT_WORD: nothing enqueued, `pc_q` holds, RUN->HALT. The buffered entries still drain.
- RUN with `pc_q`>=MEM_WORDS: nothing enqueued, RUN->FAULT. The buffered entries still drain.
- FAULT takes precedence over the halt check.
- No fetch slot in RUN (buffer full, no dequeue): stall, `pc_q` holds.
- Dequeue when `out_valid`&&`out_ready`: pop the head (FIFO order).
- Redirect in RUN has priority over fetch:
  - a dequeue in the same cycle completes normally;
  - all other entries are discarded and nothing is enqueued;
  - `pc_q`<=`redirect_pc` and the state stays RUN.
- `start` and `redirect` in the same cycle: `start` wins.
- `pc_q` arithmetic is 32-bit wrapping; it leaves the valid range through the FAULT check, not through wrap.

## Timing
- Reset values:
  - state IDLE, `pc_q`=RESET_PC, count=0;
  - `out_valid`=0, `out_instr`=0, `out_pc`=0;
  - `busy`=`halted`=`fault`=0.
- `rst` asserted mid-operation clears everything immediately (asynchronous).
- Latency from `start` in cycle N: RUN in N+1, first enqueue at the end of N+1, `out_valid`=1 in N+2.
- Redirect latency: the target instruction is valid 1 cycle after the redirect edge.
- Throughput: 1 instruction/cycle when `out_ready` stays high.
- `out_*` are registered from the buffer, with no combinational path from `out_ready`.
- `pc_o` is registered; `instr_i` is consumed combinationally, matching the zero-latency memory.

## Configuration
- `FETCH_PERF_EN` defined adds two output ports:
  - `fetch_cnt` out 32: increments on each enqueue.
  - `stall_cnt` out 32: increments each RUN cycle with a full buffer and no dequeue.
- Both counters reset to 0 on `rst` and on `start`, saturate at 32'hFFFF_FFFF and are not cleared by redirect.
- `FETCH_PERF_EN` undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- Straight-line drain: memory words 0..7 distinct, word 8 = HALT_WORD, `out_ready`=1, `start` at cycle 0 -> `out_pc` 0..7 on cycles 2..9, `halted`=1 from cycle 10, `out_valid`=0 after the last pop.
- Backpressure: `out_ready`=0 for 5 cycles after `start` -> count stops at 2 with `out_pc`=0, `pc_o`=2, and `stall_cnt` (if enabled) reaches 3. Releasing `out_ready` -> 0,1,2 delivered in order with no loss or duplicate.
- Redirect flush: redirect to 5 while the buffer holds PCs 1 and 2 and `out_ready`=1 -> PC 1 is consumed, PC 2 is dropped, the next `out_pc`=5.
- Fault: MEM_WORDS=4 with no halt word -> PCs 0..3 delivered, then `fault`=1 with `pc_o`=4. A redirect in FAULT is ignored; `start` returns to RUN at PC 0.
- Async reset mid-run: `rst` pulsed between clock edges with count=2 -> `out_valid`=0, `busy`=0 and `pc_o`=RESET_PC immediately, before the next edge.
- Priority: `start` and `redirect`(7) in the same cycle from HALT -> the first delivered `out_pc`=0.
